alu_pipe: RTL and testbench

//  Registered, parametrised ALU for the execute stage. Covers the 16 ARM data-processing

---
 rtl/alu_pipe.sv | 166 ++++++++++++++++
 tb/tb_alu_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Execute-stage ALU: the 16 ARM data-processing opcodes in a single cycle, plus an
// iterative shift-add MUL/MLA. Valid/ready on both sides; upstream stalls during multiply.
module alu_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MUL_EARLY = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             sh_c,
  input  logic [3:0]       flags_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             wr_res
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);

  localparam logic [4:0] OpAnd = 5'd0;
  localparam logic [4:0] OpEor = 5'd1;
  localparam logic [4:0] OpSub = 5'd2;
  localparam logic [4:0] OpRsb = 5'd3;
  localparam logic [4:0] OpAdd = 5'd4;
  localparam logic [4:0] OpAdc = 5'd5;
  localparam logic [4:0] OpSbc = 5'd6;
  localparam logic [4:0] OpRsc = 5'd7;
  localparam logic [4:0] OpTst = 5'd8;
  localparam logic [4:0] OpTeq = 5'd9;
  localparam logic [4:0] OpCmp = 5'd10;
  localparam logic [4:0] OpCmn = 5'd11;
  localparam logic [4:0] OpOrr = 5'd12;
  localparam logic [4:0] OpBic = 5'd14;
  localparam logic [4:0] OpMvn = 5'd15;
  localparam logic [4:0] OpMul = 5'd16;
  localparam logic [4:0] OpMla = 5'd17;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CntW-1:0]  cnt_q;
  logic [1:0]       mul_cv_q;

  // Single-cycle datapath signals
  logic [WIDTH-1:0] add_x, add_y, logic_res, dp_res;
  logic             add_cin, arith, dp_c, dp_v, dp_wr;
  logic [WIDTH:0]   sum;
  logic [3:0]       dp_flags;

  // Multiply step signals
  logic [WIDTH-1:0] step_acc, step_mcand, step_mplier;
  logic             mul_done, out_free, is_mul;

  assign out_free = !out_valid || out_ready;
  assign is_mul   = (op == OpMul) || (op == OpMla);
  assign in_ready = (state_q == StIdle) && out_free && !flush;

  // Data-processing result: all subtract forms become x + ~y + cin on one adder
  always_comb begin
    add_x     = a_in;
    add_y     = b_in;
    add_cin   = 1'b0;
    arith     = 1'b0;
    logic_res = b_in;
    case (op)
      OpAnd, OpTst: logic_res = a_in & b_in;
      OpEor, OpTeq: logic_res = a_in ^ b_in;
      OpOrr:        logic_res = a_in | b_in;
      OpBic:        logic_res = a_in & ~b_in;
      OpMvn:        logic_res = ~b_in;
      OpSub, OpCmp: begin arith = 1'b1; add_y = ~b_in; add_cin = 1'b1; end
      OpRsb:        begin arith = 1'b1; add_x = b_in; add_y = ~a_in; add_cin = 1'b1; end
      OpAdd, OpCmn: arith = 1'b1;
      OpAdc:        begin arith = 1'b1; add_cin = flags_in[1]; end
      OpSbc:        begin arith = 1'b1; add_y = ~b_in; add_cin = flags_in[1]; end
      OpRsc:        begin arith = 1'b1; add_x = b_in; add_y = ~a_in; add_cin = flags_in[1]; end
      default:      logic_res = b_in; // MOV and the unused 18-31 encodings
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    if (arith) begin
      dp_res = sum[WIDTH-1:0];
      dp_c   = sum[WIDTH];
      dp_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
    end else begin
      dp_res = logic_res;
      dp_c   = sh_c;
      dp_v   = flags_in[0];
    end
    dp_flags = {dp_res[WIDTH-1], dp_res == '0, dp_c, dp_v};
    dp_wr    = (op[4:2] != 3'b010); // TST/TEQ/CMP/CMN
  end

  // One shift-add iteration and its termination test
  always_comb begin
    step_acc    = acc_q + (mplier_q[0] ? mcand_q : '0);
    step_mcand  = mcand_q << 1;
    step_mplier = mplier_q >> 1;
    mul_done    = (cnt_q == '0) || (MUL_EARLY && (step_mplier == '0));
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      result    <= '0;
      flags_out <= '0;
      wr_res    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      mul_cv_q  <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            if (is_mul) begin
              state_q  <= StMul;
              acc_q    <= (op == OpMla) ? acc_in : '0;
              mcand_q  <= a_in;
              mplier_q <= b_in;
              cnt_q    <= CntInit;
              mul_cv_q <= flags_in[1:0];
            end else begin
              result    <= dp_res;
              flags_out <= dp_flags;
              wr_res    <= dp_wr;
              out_valid <= 1'b1;
            end
          end
        end
        StMul: begin
          // A finishing step waits while the output register is still occupied
          if (!(mul_done && !out_free)) begin
            acc_q    <= step_acc;
            mcand_q  <= step_mcand;
            mplier_q <= step_mplier;
            cnt_q    <= cnt_q - CntW'(1);
            if (mul_done) begin
              result    <= step_acc;
              flags_out <= {step_acc[WIDTH-1], step_acc == '0, mul_cv_q};
              wr_res    <= 1'b1;
              out_valid <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases then randomized traffic.
module tb_alu_pipe;
  localparam int W = 32;
  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -SMax - 1;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, sh_c, flush, out_ready;
  logic [4:0]    op;
  logic [W-1:0]  a_in, b_in, acc_in;
  logic [3:0]    flags_in;
  logic          in_ready, out_valid, wr_res;
  logic [W-1:0]  result;
  logic [3:0]    flags_out;
  logic          in_ready_f, out_valid_f, wr_res_f;
  logic [W-1:0]  result_f;
  logic [3:0]    flags_out_f;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_EARLY(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_in(a_in), .b_in(b_in), .acc_in(acc_in), .sh_c(sh_c), .flags_in(flags_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags_out(flags_out), .wr_res(wr_res)
  );

  // Full-latency multiplier variant, always ready on its output
  alu_pipe #(.WIDTH(W), .MUL_EARLY(1'b0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f), .op(op),
    .a_in(a_in), .b_in(b_in), .acc_in(acc_in), .sh_c(sh_c), .flags_in(flags_in),
    .flush(flush), .out_valid(out_valid_f), .out_ready(1'b1), .result(result_f),
    .flags_out(flags_out_f), .wr_res(wr_res_f)
  );

  typedef struct packed {
    logic         wr;
    logic [3:0]   fl;
    logic [W-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic bit ovf(input longint x);
    return (x > SMax) || (x < SMin);
  endfunction

  // Reference model: ARM semantics from plain signed/unsigned arithmetic
  function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] acc,
                                 input logic shc, input logic [3:0] fl);
    exp_t              e;
    logic [W-1:0]      r;
    logic              c, v;
    longint            sa, sb, cin, bor;
    longint unsigned   ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    cin = fl[1] ? 1 : 0;
    bor = 1 - cin;
    c   = shc;
    v   = fl[0];
    case (o)
      5'd0, 5'd8:  r = a & b;
      5'd1, 5'd9:  r = a ^ b;
      5'd12:       r = a | b;
      5'd14:       r = a & ~b;
      5'd15:       r = ~b;
      5'd2, 5'd10: begin r = a - b; c = ua >= ub; v = ovf(sa - sb); end
      5'd3:        begin r = b - a; c = ub >= ua; v = ovf(sb - sa); end
      5'd4, 5'd11: begin r = a + b; c = ((ua + ub) >> 32) != 0; v = ovf(sa + sb); end
      5'd5: begin
        r = a + b + W'(cin);
        c = ((ua + ub + longint'(cin)) >> 32) != 0;
        v = ovf(sa + sb + cin);
      end
      5'd6: begin
        r = a - b - W'(bor);
        c = ua >= ub + longint'(bor);
        v = ovf(sa - sb - bor);
      end
      5'd7: begin
        r = b - a - W'(bor);
        c = ub >= ua + longint'(bor);
        v = ovf(sb - sa - bor);
      end
      5'd16:   begin r = a * b;       c = fl[1]; v = fl[0]; end
      5'd17:   begin r = a * b + acc; c = fl[1]; v = fl[0]; end
      default: r = b;
    endcase
    e.res = r;
    e.fl  = {r[W-1], r == 0, c, v};
    e.wr  = !(o >= 5'd8 && o <= 5'd11);
    return e;
  endfunction

  // Monitor: scoreboard pops on every output handshake, plus output-hold checks
  exp_t snap;
  logic hold_p = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (hold_p) chk("hold", {31'd0, out_valid, wr_res, flags_out, result}, {31'd0, 1'b1, snap});
    if (rst_n && !flush && out_valid && !out_ready) begin
      hold_p <= 1'b1;
      snap   <= {wr_res, flags_out, result};
    end else begin
      hold_p <= 1'b0;
    end
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got=%0h want=none", result);
      end else begin
        e = exp_q.pop_front();
        chk("sb", {27'd0, wr_res, flags_out, result}, {27'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present an op and hold it until accepted; returns just after the accept edge
  task automatic issue(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] acc, input logic shc, input logic [3:0] fl,
                       output int waited);
    bit ok = 1'b0;
    op = o; a_in = a; b_in = b; acc_in = acc; sh_c = shc; flags_in = fl;
    in_valid = 1'b1;
    waited = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(o, a, b, acc, shc, fl));
        ok = 1'b1;
      end else begin
        waited++;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=no_accept want=accept op=%0d", o);
    end
    if (o == 5'd16 || o == 5'd17) in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 want=1");
    end
  endtask

  task automatic dp_direct(input string name, input logic [4:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [3:0] fl,
                           input logic [W-1:0] want_r, input logic [3:0] want_f,
                           input logic want_w);
    int w;
    issue(o, a, b, '0, 1'b0, fl, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, "_res"}, {32'd0, result}, {32'd0, want_r});
    chk({name, "_nzcv"}, {60'd0, flags_out}, {60'd0, want_f});
    chk({name, "_wr"}, {63'd0, wr_res}, {63'd0, want_w});
    step();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int n, w;
    logic [4:0] o;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a_in = '0; b_in = '0; acc_in = '0;
    sh_c = 1'b0; flags_in = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_res", {32'd0, result}, 64'd0);
    chk("rst_flags", {59'd0, wr_res, flags_out}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    step();
    rst_n = 1'b1;
    step();

    dp_direct("add_ovf", 5'd4, 32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 4'b1001, 1'b1);
    dp_direct("cmp_eq", 5'd10, 32'd5, 32'd5, 4'b0000, 32'd0, 4'b0110, 1'b0);
    dp_direct("sbc_c0", 5'd6, 32'd0, 32'd0, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 1'b1);

    // Full-latency multiply on the MUL_EARLY=0 instance
    issue(5'd16, 32'h1_0000, 32'h1_0000, '0, 1'b0, 4'b0011, w);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready_f) break;
      n++;
      step();
    end
    chk("mul_busy", 64'(n), 64'd32);
    chk("mul_full_out", {27'd0, out_valid_f, wr_res_f, flags_out_f, result_f},
        {27'd0, 1'b1, 1'b1, 4'b0111, 32'd0});
    step();
    wait_ready();

    // Early-terminating MLA: 3*4+10
    issue(5'd17, 32'd3, 32'd4, 32'd10, 1'b0, 4'b0000, w);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      step();
    end
    chk("mla_lat", 64'(n), 64'd3);
    chk("mla_res", {32'd0, result}, 64'd22);
    step();
    wait_ready();

    // Back-to-back ADDs against a stalled output
    out_ready = 1'b0;
    issue(5'd4, 32'd10, 32'd20, '0, 1'b0, 4'b0000, w);
    op = 5'd4; a_in = 32'd100; b_in = 32'd200; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rdy", {63'd0, in_ready}, 64'd0);
      chk("stall_res", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd30});
      step();
    end
    out_ready = 1'b1;
    issue(5'd4, 32'd100, 32'd200, '0, 1'b0, 4'b0000, w);
    chk("b2b_accept", 64'(w), 64'd0);
    in_valid = 1'b0;
    step(); step();

    // Flush in the fifth cycle of a multiply, with an op presented that cycle
    issue(5'd16, 32'h1234_5678, 32'hFFFF_FFFF, '0, 1'b0, 4'b0000, w);
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    op = 5'd4; a_in = 32'd9; b_in = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_rdy", {63'd0, in_ready}, 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_after", {62'd0, out_valid, in_ready}, 64'd1);
    step();
    dp_direct("flush_add", 5'd4, 32'd1, 32'd1, 4'b0000, 32'd2, 4'b0000, 1'b1);

    // Reset in the fifth cycle of a multiply
    issue(5'd17, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd7, 1'b0, 4'b0000, w);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_ctl", {62'd0, out_valid, in_ready}, 64'd1);
    chk("rst_mid_out", {27'd0, wr_res, flags_out, result}, 64'd0);
    step();
    dp_direct("rst_add", 5'd4, 32'd1, 32'd1, 4'b0000, 32'd2, 4'b0000, 1'b1);

    // Randomized traffic with random output back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      o = 5'($urandom_range(0, 31));
      issue(o, pick(), pick(), pick(), 1'($urandom), 4'($urandom), w);
      if (o == 5'd16 || o == 5'd17) wait_ready();
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
